pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16: counter and address width, legal range 4..32.
REQ-002 SHALL have parameter RESET_VEC, default 0: value of pc after reset.
REQ-003 SHALL have parameter RAS_DEPTH, default 4: return-stack entries, power of two, 2..16.
REQ-004 SHALL have port clk  in  1: the only clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n  in  1: reset, asynchronous and active-low.
REQ-006 SHALL have port en  in  1: advance enable; 0 means stall.
REQ-007 SHALL have port step  in  4: unsigned increment amount, 0..15.
REQ-008 SHALL have port load  in  1: jump request.
REQ-009 SHALL have port load_val  in  WIDTH: jump or call target.
REQ-010 SHALL have port call  in  1: call request (PC_RAS_EN only).
REQ-011 SHALL have port ret  in  1: return request (PC_RAS_EN only).
REQ-012 SHALL have port pc  out  WIDTH: registered current address.
REQ-013 SHALL have port pc_inc  out  WIDTH: combinational value pc + step, modulo 2^WIDTH.
REQ-014 SHALL have port wrap  out  1: registered pulse; the last increment carried out of bit WIDTH-1.
REQ-015 SHALL have port ras_empty  out  1: return stack empty (PC_RAS_EN only).
REQ-016 SHALL have port ras_full  out  1: return stack full (PC_RAS_EN only).
REQ-017 SHALL have port ras_err  out  1: registered one-cycle pulse for an illegal stack operation (PC_RAS_EN only).

Function
REQ-018 SHALL, when en=0, hold pc and stack state, ignore load, call and ret, and drive wrap=0 and ras_err=0 on the next cycle.
REQ-019 SHALL, when en=1, resolve requests in this priority order, highest first: ret, call, load, increment.
REQ-020 SHALL, on increment (en=1, no request), set pc <= pc + step modulo 2^WIDTH, with one-cycle latency.
REQ-021 SHALL assert wrap for exactly one cycle after an increment whose true sum is at least 2^WIDTH; step=0 never wraps.
REQ-022 SHALL, on load, set pc <= load_val and wrap <= 0.
REQ-023 SHALL, on call, push pc_inc onto the stack and set pc <= load_val in the same cycle.
REQ-024 SHALL, on ret with a non-empty stack, set pc <= top entry and pop it.
REQ-025 SHALL, when call and ret are both 1, perform only the ret; this is legal and does not raise ras_err.
REQ-026 SHALL, on call with the stack full, overwrite the oldest entry, keep the entry count at RAS_DEPTH, jump normally, and pulse ras_err.
REQ-027 SHALL, on ret with the stack empty, hold pc, leave the stack unchanged, and pulse ras_err.
REQ-028 SHALL derive ras_empty and ras_full from the registered entry count, so both reflect the state after the previous edge.
REQ-029 SHALL hold RAS_DEPTH-1 entries when a full-stack call is followed by a ret.

Reset
REQ-030 SHALL, while reset_n=0, immediately force pc=RESET_VEC, wrap=0, ras_err=0, entry count=0 (ras_empty=1, ras_full=0); stack contents are don't-care.
REQ-031 SHALL, when reset asserts mid-call or mid-ret, abandon the operation with no partial push or pop.
REQ-032 SHALL sample no inputs on the first rising clk edge after reset_n deasserts.

Configuration
REQ-033 SHALL, with macro PC_RAS_EN defined, include the return stack, the call and ret ports, and the ras_* outputs.
REQ-034 SHALL, without PC_RAS_EN, omit those ports and all stack logic, leaving priority order load, then increment.

Verification
REQ-035 SHALL cover: reset_n=0 mid-run with RESET_VEC=0x0100 -> pc=0x0100 immediately, wrap=0.
REQ-036 SHALL cover: WIDTH=16, pc=0xFFFE, step=3, en=1 -> pc=0x0001, wrap=1 for one cycle, then 0.
REQ-037 SHALL cover: pc=0x0010, en=0, load=1, step=5 for 3 cycles -> pc stays 0x0010; then en=1, load=1, load_val=0x2000 -> pc=0x2000.
REQ-038 SHALL cover: pc=0x0040, step=1, call=1, load_val=0x0500 -> pc=0x0500, ras_empty=0; then ret=1 -> pc=0x0041, ras_empty=1.
REQ-039 SHALL cover: RAS_DEPTH=4, five nested calls -> ras_err on the fifth, ras_full=1; four rets return newest-first; a fifth ret -> pc held, ras_err pulse.
REQ-040 SHALL cover: call=1 and ret=1 together with one stack entry 0x0123 -> pc=0x0123, stack empty, ras_err=0.

Source files
------------

// File: rtl/pc_unit.sv
// -----------------------------------------------------------------------------
// pc_unit: program counter with stall, stepped increment, jump and an optional
// return-address stack for call/return.
//
// Optional feature macro: PC_RAS_EN
//   Defined   -> return stack present; ports call, ret, ras_empty, ras_full and
//                ras_err exist. Priority: ret, call, load, increment.
//   Undefined -> no stack logic and none of those ports. Priority: load, then
//                increment.
//
// Parameters
//   WIDTH     : counter/address width (4..32)
//   RESET_VEC : pc value after reset
//   RAS_DEPTH : return stack entries (power of two, 2..16)
//
// Ports
//   clk       in   1      rising-edge clock
//   reset_n   in   1      asynchronous active-low reset
//   en        in   1      advance enable, 0 stalls everything
//   step      in   4      unsigned increment amount
//   load      in   1      jump request
//   load_val  in   WIDTH  jump/call target
//   call      in   1      call request (PC_RAS_EN)
//   ret       in   1      return request (PC_RAS_EN)
//   pc        out  WIDTH  registered current address
//   pc_inc    out  WIDTH  combinational pc + step (mod 2^WIDTH)
//   wrap      out  1      registered pulse: last increment carried out
//   ras_empty out  1      stack empty (PC_RAS_EN)
//   ras_full  out  1      stack full (PC_RAS_EN)
//   ras_err   out  1      registered pulse on illegal stack op (PC_RAS_EN)
// -----------------------------------------------------------------------------
module pc_unit #(
    parameter int unsigned      WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VEC = '0,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [3:0]       step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
`ifdef PC_RAS_EN
    input  logic             call,
    input  logic             ret,
`endif
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_inc,
    output logic             wrap
`ifdef PC_RAS_EN
    ,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_err
`endif
);

    // One extra bit keeps the carry out of the increment.
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] pc_d;
    logic             wrap_d;
    logic             started_q;
    logic             advance;

    assign sum    = {1'b0, pc} + {{(WIDTH - 3){1'b0}}, step};
    assign pc_inc = sum[WIDTH-1:0];

    // Cleared by reset and set on the first edge afterwards, so that first
    // edge ignores all inputs and simply holds state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            started_q <= 1'b0;
        end else begin
            started_q <= 1'b1;
        end
    end

    assign advance = en & started_q;

`ifdef PC_RAS_EN
    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    // Circular buffer: top_q points at the newest entry. A push onto a full
    // stack lands on the oldest slot, which is exactly the overwrite wanted.
    logic [WIDTH-1:0] stack_q [RAS_DEPTH];
    logic [PTR_W-1:0] top_q, top_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             push;
    logic             err_d, err_q;
    logic             empty, full;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_W'(RAS_DEPTH));
`endif

    always_comb begin
        pc_d   = pc;
        wrap_d = 1'b0;
`ifdef PC_RAS_EN
        push   = 1'b0;
        top_d  = top_q;
        cnt_d  = cnt_q;
        err_d  = 1'b0;
`endif
        if (advance) begin
`ifdef PC_RAS_EN
            if (ret) begin
                // ret wins over a simultaneous call; empty stack holds pc.
                if (empty) begin
                    err_d = 1'b1;
                end else begin
                    pc_d  = stack_q[top_q];
                    top_d = top_q - PTR_W'(1);
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end else if (call) begin
                push  = 1'b1;
                pc_d  = load_val;
                top_d = top_q + PTR_W'(1);
                if (full) begin
                    err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else
`endif
            if (load) begin
                pc_d = load_val;
            end else begin
                pc_d   = sum[WIDTH-1:0];
                wrap_d = sum[WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc   <= RESET_VEC;
            wrap <= 1'b0;
        end else begin
            pc   <= pc_d;
            wrap <= wrap_d;
        end
    end

`ifdef PC_RAS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            top_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Contents need no reset; push is gated by started_q, so a reset landing
    // mid-call never writes an entry.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[top_d] <= pc_inc;
        end
    end

    assign ras_empty = empty;
    assign ras_full  = full;
    assign ras_err   = err_q;
`endif

endmodule

// File: tb/tb_pc_unit.sv
module tb_pc_unit;

    localparam int          W  = 16;
    localparam logic [15:0] RV = 16'h0100;
    localparam int          D  = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic [3:0]  step = '0;
    logic        load = 1'b0;
    logic [15:0] load_val = '0;
    logic        call = 1'b0;
    logic        ret = 1'b0;
    logic [15:0] pc;
    logic [15:0] pc_inc;
    logic        wrap;
`ifdef PC_RAS_EN
    logic        ras_empty, ras_full, ras_err;
`endif

    pc_unit #(
        .WIDTH     (W),
        .RESET_VEC (RV),
        .RAS_DEPTH (D)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .step      (step),
        .load      (load),
        .load_val  (load_val),
`ifdef PC_RAS_EN
        .call      (call),
        .ret       (ret),
`endif
        .pc        (pc),
        .pc_inc    (pc_inc),
        .wrap      (wrap)
`ifdef PC_RAS_EN
        ,
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_err   (ras_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic        wrap;
        logic        err;
        logic        empty;
        logic        full;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    // Reference model: architectural pc, a queue as the stack (back = newest).
    logic [15:0] m_pc = RV;
    bit          m_first = 1'b1;
    int          m_stack[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: one architectural state per rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pc", 32'(pc), 32'(e.pc));
                chk("wrap", 32'(wrap), 32'(e.wrap));
`ifdef PC_RAS_EN
                chk("ras_err", 32'(ras_err), 32'(e.err));
                chk("ras_empty", 32'(ras_empty), 32'(e.empty));
                chk("ras_full", 32'(ras_full), 32'(e.full));
`endif
            end
        end
    end

    // One clock of stimulus; the model predicts the state after the next edge.
    task automatic cycle(input bit rst, input bit e, input logic [3:0] s, input bit ld,
                         input logic [15:0] lv, input bit c, input bit r);
        exp_t x;
        int   sum;
        bit   cc, rr;
        @(negedge clk);
        reset_n  = !rst;
        en       = e;
        step     = s;
        load     = ld;
        load_val = lv;
        call     = c;
        ret      = r;
        cc = c;
        rr = r;
`ifndef PC_RAS_EN
        cc = 1'b0;
        rr = 1'b0;
`endif
        x.err  = 1'b0;
        x.wrap = 1'b0;
        if (rst) begin
            m_pc = RV;
            m_stack.delete();
            m_first = 1'b1;
            #1;
            chk("rst_pc_now", 32'(pc), 32'(RV));
            chk("rst_wrap_now", 32'(wrap), 32'd0);
        end else begin
            #1;
        end
        sum = int'(m_pc) + int'(s);
        chk("pc_inc", 32'(pc_inc), 32'(sum % 65536));
        if (rst) begin
            // state stays at reset
        end else if (m_first) begin
            m_first = 1'b0;
        end else if (!e) begin
            // stall
        end else if (rr) begin
            if (m_stack.size() == 0) x.err = 1'b1;
            else m_pc = 16'(m_stack.pop_back());
        end else if (cc) begin
            m_stack.push_back(sum % 65536);
            if (m_stack.size() > D) begin
                void'(m_stack.pop_front());
                x.err = 1'b1;
            end
            m_pc = lv;
        end else if (ld) begin
            m_pc = lv;
        end else begin
            x.wrap = (sum >= 65536);
            m_pc = 16'(sum % 65536);
        end
        x.pc    = m_pc;
        x.empty = (m_stack.size() == 0);
        x.full  = (m_stack.size() == D);
        sb.push_back(x);
    endtask

    initial begin
        // Power-on reset, release (first edge holds), a couple of increments.
        repeat (3) cycle(1, 1, 4'd7, 0, 16'h0, 0, 0);
        cycle(0, 1, 4'd7, 1, 16'h5555, 0, 0);
        cycle(0, 1, 4'd3, 0, 16'h0, 0, 0);
        cycle(0, 1, 4'd15, 0, 16'h0, 0, 0);
        // Wrap at the top of the range, then a non-wrapping step=0.
        cycle(0, 1, 4'd0, 1, 16'hFFFE, 0, 0);
        cycle(0, 1, 4'd3, 0, 16'h0, 0, 0);
        cycle(0, 1, 4'd0, 0, 16'h0, 0, 0);
        // Stall ignores load, then a real load.
        cycle(0, 1, 4'd0, 1, 16'h0010, 0, 0);
        repeat (3) cycle(0, 0, 4'd5, 1, 16'h1234, 1, 1);
        cycle(0, 1, 4'd5, 1, 16'h2000, 0, 0);
        // Reset mid-run while wrap is high.
        cycle(0, 1, 4'd0, 1, 16'hFFFF, 0, 0);
        cycle(0, 1, 4'd2, 0, 16'h0, 0, 0);
        cycle(1, 1, 4'd2, 0, 16'h0, 0, 0);
        cycle(0, 1, 4'd2, 0, 16'h0, 0, 0);
`ifdef PC_RAS_EN
        // Call then return.
        cycle(0, 1, 4'd0, 1, 16'h0040, 0, 0);
        cycle(0, 1, 4'd1, 0, 16'h0500, 1, 0);
        cycle(0, 1, 4'd1, 0, 16'h0000, 0, 1);
        // Five nested calls overflow, five returns underflow.
        for (int i = 1; i <= 5; i++) cycle(0, 1, 4'd2, 0, 16'(i * 16'h0100), 1, 0);
        for (int i = 0; i < 5; i++) cycle(0, 1, 4'd0, 0, 16'h0, 0, 1);
        // Simultaneous call+ret with one entry 0x0123.
        cycle(1, 1, 4'd0, 0, 16'h0, 0, 0);
        cycle(0, 1, 4'd0, 0, 16'h0, 0, 0);
        cycle(0, 1, 4'd0, 1, 16'h0120, 0, 0);
        cycle(0, 1, 4'd3, 0, 16'h0500, 1, 0);
        cycle(0, 1, 4'd3, 0, 16'h0777, 1, 1);
        // Reset while call is requested: nothing pushed.
        cycle(0, 1, 4'd1, 0, 16'h0300, 1, 0);
        cycle(1, 1, 4'd1, 0, 16'h0300, 1, 0);
        cycle(0, 1, 4'd1, 0, 16'h0300, 0, 1);
        cycle(0, 1, 4'd1, 0, 16'h0300, 0, 1);
`endif
        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 59) == 0, $urandom_range(0, 7) != 0,
                  4'($urandom_range(0, 15)), $urandom_range(0, 7) == 0,
                  16'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
        end
        repeat (2) cycle(0, 0, 4'd0, 0, 16'h0, 0, 0);
        @(posedge clk);
        #2;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
